// File: rtl/packet_length_checker.sv
// Checks sop/eop framing and length-vs-beats, forwarding beats through a 1-deep output register.
// Latency: 1 cycle from accepted beat to ovalid; full throughput of 1 beat/cycle.
// Backpressure: iready = !ovalid | oready; outputs hold while ovalid & !oready. Stats: PKT_CHECK_STATS_EN.
module packet_length_checker #(
    parameter int DATA_WIDTH = 64,
    parameter int PLEN_WIDTH = 14,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  iclk,
    input  logic                  irst_n,
    input  logic                  ivalid,
    input  logic                  isop,
    input  logic                  ieop,
    input  logic [DATA_WIDTH-1:0] idata,
    input  logic [PLEN_WIDTH-1:0] iplen,
    input  logic                  ibad,
    output logic                  iready,
    output logic                  ovalid,
    output logic                  osop,
    output logic                  oeop,
    output logic [DATA_WIDTH-1:0] odata,
    output logic                  oerr,
    input  logic                  oready,
    output logic [CNT_WIDTH-1:0]  good_cnt,
    output logic [CNT_WIDTH-1:0]  err_cnt,
    output logic [CNT_WIDTH-1:0]  drop_cnt
);

    localparam int BPB   = DATA_WIDTH / 8;
    localparam int EXP_W = 12;

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_IN_PKT = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [EXP_W-1:0]        r_beats;
    logic [EXP_W-1:0]        w_beats_nxt;
    logic [EXP_W-1:0]        r_exp;
    logic [EXP_W-1:0]        w_exp_nxt;
    logic [EXP_W-1:0]        w_exp_in;
    logic [EXP_W-1:0]        w_beats_inc;
    logic                    r_err;
    logic                    w_err_nxt;
    logic [PLEN_WIDTH:0]     w_plen_rnd;

    logic                    w_acc;
    logic                    w_emit;
    logic                    w_emit_sop;
    logic                    w_emit_eop;
    logic                    w_emit_err;

    logic                    r_ovalid;
    logic                    r_osop;
    logic                    r_oeop;
    logic                    r_oerr;
    logic [DATA_WIDTH-1:0]   r_odata;

    assign iready = !r_ovalid || oready;
    assign w_acc  = ivalid && iready;

    // Expected beat count, rounded up to whole beats.
    assign w_plen_rnd  = {1'b0, iplen} + (PLEN_WIDTH+1)'(BPB - 1);
    assign w_exp_in    = EXP_W'(w_plen_rnd / (PLEN_WIDTH+1)'(BPB));
    assign w_beats_inc = (r_beats == {EXP_W{1'b1}}) ? r_beats : r_beats + EXP_W'(1);

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            r_state <= S_IDLE;
            r_beats <= '0;
            r_exp   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_beats <= w_beats_nxt;
            r_exp   <= w_exp_nxt;
            r_err   <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_beats_nxt = r_beats;
        w_exp_nxt   = r_exp;
        w_err_nxt   = r_err;
        w_emit      = 1'b0;
        w_emit_sop  = 1'b0;
        w_emit_eop  = 1'b0;
        w_emit_err  = 1'b0;
        if (w_acc) begin
            case (r_state)
                S_IDLE: begin
                    if (isop) begin
                        w_emit      = 1'b1;
                        w_emit_sop  = 1'b1;
                        w_exp_nxt   = w_exp_in;
                        w_beats_nxt = EXP_W'(1);
                        w_err_nxt   = ibad || (iplen == '0);
                        if (ieop) begin
                            w_emit_eop = 1'b1;
                            w_emit_err = w_err_nxt || (w_exp_in != EXP_W'(1));
                        end else begin
                            w_state_nxt = S_IN_PKT;
                        end
                    end
                end
                S_IN_PKT: begin
                    w_emit = 1'b1;
                    if (isop) begin
                        // A sop inside an open packet truncates it; the new packet is not opened.
                        w_emit_eop  = 1'b1;
                        w_emit_err  = 1'b1;
                        w_beats_nxt = '0;
                        w_err_nxt   = 1'b0;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_beats_nxt = w_beats_inc;
                        w_err_nxt   = r_err || ibad || (w_beats_inc > r_exp);
                        if (ieop) begin
                            w_emit_eop  = 1'b1;
                            w_emit_err  = w_err_nxt || (w_beats_inc != r_exp);
                            w_state_nxt = S_IDLE;
                        end
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            r_ovalid <= 1'b0;
            r_osop   <= 1'b0;
            r_oeop   <= 1'b0;
            r_oerr   <= 1'b0;
            r_odata  <= '0;
        end else if (w_emit) begin
            r_ovalid <= 1'b1;
            r_osop   <= w_emit_sop;
            r_oeop   <= w_emit_eop;
            r_oerr   <= w_emit_err;
            r_odata  <= idata;
        end else if (oready) begin
            r_ovalid <= 1'b0;
        end
    end

    assign ovalid = r_ovalid;
    assign osop   = r_osop;
    assign oeop   = r_oeop;
    assign oerr   = r_oerr;
    assign odata  = r_odata;

`ifdef PKT_CHECK_STATS_EN
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    logic [CNT_WIDTH-1:0] r_good_cnt;
    logic [CNT_WIDTH-1:0] r_err_cnt;
    logic [CNT_WIDTH-1:0] r_drop_cnt;
    logic                 w_xfer_eop;
    logic                 w_drop;

    assign w_xfer_eop = r_ovalid && oready && r_oeop;
    assign w_drop     = w_acc && (r_state == S_IDLE) && !isop;

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            r_good_cnt <= '0;
            r_err_cnt  <= '0;
            r_drop_cnt <= '0;
        end else begin
            if (w_xfer_eop && !r_oerr && (r_good_cnt != {CNT_WIDTH{1'b1}}))
                r_good_cnt <= r_good_cnt + CNT_ONE;
            if (w_xfer_eop && r_oerr && (r_err_cnt != {CNT_WIDTH{1'b1}}))
                r_err_cnt <= r_err_cnt + CNT_ONE;
            if (w_drop && (r_drop_cnt != {CNT_WIDTH{1'b1}}))
                r_drop_cnt <= r_drop_cnt + CNT_ONE;
        end
    end

    assign good_cnt = r_good_cnt;
    assign err_cnt  = r_err_cnt;
    assign drop_cnt = r_drop_cnt;
`else
    assign good_cnt = '0;
    assign err_cnt  = '0;
    assign drop_cnt = '0;
`endif

endmodule
